// File: rtl/arcade_input_ctrl.sv
// arcade_input_ctrl
//   Merges PS/2 keyboard keys and joystick bits into one active-low arcade
//   button vector, optionally rotating directions for horizontal cabinets.
//   Any start or coin request fires a fixed-width coin pulse followed by a
//   lockout gap; requests during pulse or gap are dropped.
//
// Ports
//   clk        system clock
//   RESET      synchronous, active-high reset
//   ps2_key    [10] event toggle, [9] pressed, [8:0] scan code
//   joy        [0] right [1] left [2] down [3] up [4] fire
//              [5] start1 [6] start2 [7] coin (active-high)
//   rotate     1 = horizontal orientation, remaps directions
//   button_n   registered, active-low
//              {start2, fire, coin, start1, right, left, down, up}
//   coin_busy  high while the coin FSM is not idle
module arcade_input_ctrl #(
    parameter logic [23:0] COIN_LEN = 24'd600000,
    parameter logic [23:0] COIN_GAP = 24'd1200000
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joy,
    input  logic        rotate,
    output logic [7:0]  button_n,
    output logic        coin_busy
);

    typedef enum logic [1:0] {IDLE, PULSE, GAP} coin_state_t;

    coin_state_t state, next_state;
    logic [23:0] cnt, next_cnt;
    logic        coin;

    logic toggle_q;
    logic key_up, key_down, key_left, key_right;
    logic key_fire_a, key_fire_b, key_start1, key_start2, key_coin;

    logic m_up, m_down, m_left, m_right, m_fire, m_start1, m_start2, m_coin;
    logic out_up, out_down, out_left, out_right;
    logic req, req_q, trig_q;
    logic key_event;

    // Bits with no function here; the name keeps them out of unused-signal lint.
    logic unused_bits;
    assign unused_bits = ^{joy[15:8], ps2_key[8]};

    assign key_event = ps2_key[10] ^ toggle_q;

    // Merged keyboard/joystick view; the two fire keys are independent latches.
    assign m_up     = key_up     | joy[3];
    assign m_down   = key_down   | joy[2];
    assign m_left   = key_left   | joy[1];
    assign m_right  = key_right  | joy[0];
    assign m_fire   = key_fire_a | key_fire_b | joy[4];
    assign m_start1 = key_start1 | joy[5];
    assign m_start2 = key_start2 | joy[6];
    assign m_coin   = key_coin   | joy[7];

    // Horizontal cabinet: the stick is turned a quarter turn.
    assign out_up    = rotate ? m_left  : m_up;
    assign out_down  = rotate ? m_right : m_down;
    assign out_left  = rotate ? m_down  : m_left;
    assign out_right = rotate ? m_up    : m_right;

    assign req = m_start1 | m_start2 | m_coin;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        toggle_q <= ps2_key[10];
        if (RESET) begin
            key_up     <= 1'b0;
            key_down   <= 1'b0;
            key_left   <= 1'b0;
            key_right  <= 1'b0;
            key_fire_a <= 1'b0;
            key_fire_b <= 1'b0;
            key_start1 <= 1'b0;
            key_start2 <= 1'b0;
            key_coin   <= 1'b0;
            // Track the live request so a request held through reset is not
            // seen as a fresh rising edge afterwards.
            req_q      <= req;
            trig_q     <= 1'b0;
            button_n   <= 8'hFF;
        end else begin
            if (key_event) begin
                // Scan code bit 8 (extended prefix) is ignored.
                case (ps2_key[7:0])
                    8'h75:   key_up     <= ps2_key[9];
                    8'h72:   key_down   <= ps2_key[9];
                    8'h6B:   key_left   <= ps2_key[9];
                    8'h74:   key_right  <= ps2_key[9];
                    8'h29:   key_fire_a <= ps2_key[9];
                    8'h14:   key_fire_b <= ps2_key[9];
                    8'h05:   key_start1 <= ps2_key[9];
                    8'h06:   key_start2 <= ps2_key[9];
                    8'h2E:   key_coin   <= ps2_key[9];
                    default: ;
                endcase
            end
            req_q    <= req;
            trig_q   <= req & ~req_q;
            button_n <= ~{m_start2, m_fire, coin, m_start1,
                          out_right, out_left, out_down, out_up};
        end
    end

    // Coin FSM: state register.
    always_ff @(posedge clk) begin
        if (RESET) begin
            state <= IDLE;
            cnt   <= 24'd0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Coin FSM: next state. Triggers outside IDLE are simply ignored.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; a missing
        // assignment in any branch would infer a latch.
        next_state = state;
        next_cnt   = cnt;
        case (state)
            IDLE: begin
                if (trig_q) begin
                    next_state = PULSE;
                    next_cnt   = COIN_LEN - 24'd1;
                end
            end
            PULSE: begin
                if (cnt == 24'd0) begin
                    next_state = GAP;
                    next_cnt   = COIN_GAP - 24'd1;
                end else begin
                    next_cnt = cnt - 24'd1;
                end
            end
            GAP: begin
                if (cnt == 24'd0) next_state = IDLE;
                else              next_cnt   = cnt - 24'd1;
            end
            default: begin
                next_state = IDLE;
                next_cnt   = 24'd0;
            end
        endcase
    end

    // Coin FSM: outputs.
    always_comb begin
        coin      = (state == PULSE);
        coin_busy = (state != IDLE);
    end

endmodule

// File: doc/arcade_input_ctrl.md
ARCADE_INPUT_CTRL -- requirements
Module: arcade_input_ctrl

Interface
REQ-001 The module SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 The module SHALL have parameter COIN_LEN, default 24'd600000, giving the coin pulse length in clk cycles (legal range 1..2^24-1).
REQ-003 The module SHALL have parameter COIN_GAP, default 24'd1200000, giving the post-pulse lockout in clk cycles (legal range 1..2^24-1).
REQ-004 The module SHALL have port `clk` (input, 1): system clock.
REQ-005 The module SHALL have port `RESET` (input, 1): synchronous, active-high.
REQ-006 The module SHALL have port `ps2_key` (input, 11): [10] event toggle, [9] pressed, [8:0] scan code.
REQ-007 The module SHALL have port `joy` (input, 16): [0] right, [1] left, [2] down, [3] up, [4] fire, [5] start1, [6] start2, [7] coin; all active-high.
REQ-008 The module SHALL have port `rotate` (input, 1): 1 = horizontal orientation, which remaps directions.
REQ-009 The module SHALL have port `button_n` (output, 8): active-low {start2, fire, coin, start1, right, left, down, up}, registered.
REQ-010 The module SHALL have port `coin_busy` (output, 1): high while the coin FSM is not in IDLE.

Function
REQ-011 A keyboard event SHALL be ps2_key[10] != toggle_q, where toggle_q is registered every cycle.
REQ-012 On an event, the key latch selected by code SHALL be loaded with ps2_key[9]; all other latches SHALL hold.
REQ-013 Key map (code bit 8 ignored):
  - x75 = up, x72 = down, x6B = left, x74 = right
  - 029 = fire_a, 014 = fire_b
  - 005 = start1, 006 = start2, 02E = coin
REQ-014 Unmapped codes SHALL cause no state change.
REQ-015 fire SHALL equal fire_a | fire_b, so releasing one fire key does not cancel the other.
REQ-016 Merged signals SHALL be key | joy bit for each of up, down, left, right, fire, start1, start2, coin_req.
REQ-017 With rotate=1, outputs SHALL be remapped as: up<=left, down<=right, left<=down, right<=up.
REQ-018 With rotate=0, directions SHALL pass straight through.
REQ-019 The rotate input SHALL take effect on the next registered output.
REQ-020 trig SHALL be the rising edge of (start1 | start2 | coin_req), taken from the merged signals through one registered stage.
REQ-021 Coin FSM in IDLE: on trig, go to PULSE and load cnt=COIN_LEN-1.
REQ-022 Coin FSM in PULSE: coin=1; when cnt==0, go to GAP and load cnt=COIN_GAP-1; otherwise decrement cnt.
REQ-023 Coin FSM in GAP: coin=0; when cnt==0, go to IDLE; otherwise decrement cnt.
REQ-024 Any trig arriving while in PULSE or GAP SHALL be dropped, not queued.
REQ-025 A request held high continuously SHALL produce exactly one pulse.
REQ-026 The coin pulse SHALL be exactly COIN_LEN cycles wide.
REQ-027 Successive coin pulses SHALL start at least COIN_LEN+COIN_GAP cycles apart.
REQ-028 Latency, joystick change: button_n SHALL update at the 1st rising edge.
REQ-029 Latency, keyboard event: latch updates at edge 1 and button_n updates at edge 2.
REQ-030 Latency, coin: with trig sampled at edge N, state=PULSE at edge N+1 and button_n[5] falls at edge N+2.
REQ-031 Simultaneous key event and joystick change in the same cycle SHALL both be honoured (OR'd); no priority is needed.
REQ-032 A key event for the same code as the previous event SHALL simply reload that latch with the new pressed value.

Reset
REQ-033 While RESET=1: all key latches=0, FSM=IDLE, cnt=0, coin=0, trig history=0.
REQ-034 While RESET=1: toggle_q SHALL load ps2_key[10], so no spurious event occurs after reset.
REQ-035 While RESET=1: button_n SHALL be 8'hFF and coin_busy SHALL be 0.
REQ-036 RESET asserted mid-PULSE or mid-GAP SHALL abort to IDLE, with coin low on the next edge.
REQ-037 After reset releases, a still-held request SHALL NOT retrigger until it is released and pressed again.

Verification
REQ-038 Reset with joy=0 and no events -> button_n=8'hFF and coin_busy=0 for 100 cycles.
REQ-039 Toggle ps2_key with code 0x175, pressed=1 -> button_n[0]=0 two edges later.
REQ-040 Toggle ps2_key with code 0x175, pressed=0 -> button_n[0]=1 two edges later.
REQ-041 Press 029, then 014, then release 029 -> button_n[6] stays 0.
REQ-042 From REQ-041, release 014 -> button_n[6]=1.
REQ-043 rotate=1, joy[3]=1 -> button_n=8'hF7 (right asserted) one edge later.
REQ-044 rotate=0, joy[3]=1 -> button_n=8'hFE.
REQ-045 COIN_LEN=4, COIN_GAP=6, joy[5] held for 30 cycles -> exactly one coin pulse; button_n[5]=0 for exactly 4 cycles.
REQ-046 From REQ-045, coin_busy high for exactly 10 cycles.
REQ-047 From REQ-045, a second joy[5] press at cycle 8 after the first is ignored; a press after coin_busy falls yields a new pulse.
REQ-048 RESET pulsed for 1 cycle mid-PULSE -> coin_busy=0 and button_n[5]=1 within 2 edges.
REQ-049 From REQ-048, a held joy[7] produces no pulse until released and re-pressed.
